activation_serializer: RTL

Reads the wide activated vector produced by the ReLU activation stage and streams it out one node per beat over a valid/ready handshake. It sits after the activation stage and turns its parallel `output_fc` bus plus level `done_flag` into a narrow stream for the next layer's weight-multiply engine or the result buffer. It captures a full frame on the rising edge of `done_flag`, then emits nodes 0..OUTPUT_NODES-1 in order.

---
 rtl/activation_serializer_if.sv | 28 ++
 rtl/activation_serializer.sv | 119 +++++++++++
 2 files changed

// File: rtl/activation_serializer_if.sv
// Beat stream carried from activation_serializer to the next-layer consumer.
// master drives data/index/valid/last, slave drives ready.
interface activation_serializer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_WIDTH-1:0]  out_index;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/activation_serializer.sv
// Captures the activated vector on the rising edge of done_flag and streams it one node per beat.
// Optional `ACT_SER_ZERO_SKIP_EN: zero-valued nodes (except the last) are not emitted.
module activation_serializer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned OUTPUT_NODES = 256,
    parameter int unsigned IDX_WIDTH    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] input_fc,
    input  logic                               done_flag,
    activation_serializer_if.master            stream,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               drop_err
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(OUTPUT_NODES - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                             state_q;
    logic                               done_prev_q;
    logic [DATA_WIDTH*OUTPUT_NODES-1:0] frame_q;

    logic                  start_edge;
    logic                  capture;
    logic                  beat_accept;
    logic [IDX_WIDTH-1:0]  first_idx;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic [DATA_WIDTH-1:0] first_data;
    logic [DATA_WIDTH-1:0] next_data;

    assign start_edge  = done_flag && !done_prev_q;
    assign capture     = (state_q == StIdle) && start_edge;
    assign beat_accept = stream.out_valid && stream.out_ready;

`ifdef ACT_SER_ZERO_SKIP_EN
    // Descending scan so the last hit is the lowest qualifying nonzero node;
    // the final node is the fallback terminator.
    always_comb begin
        first_idx = LastIdx;
        next_idx  = LastIdx;
        for (int i = int'(OUTPUT_NODES) - 2; i >= 0; i--) begin
            if (input_fc[DATA_WIDTH*i +: DATA_WIDTH] != '0) begin
                first_idx = IDX_WIDTH'(i);
            end
            if ((i > int'(stream.out_index)) && (frame_q[DATA_WIDTH*i +: DATA_WIDTH] != '0)) begin
                next_idx = IDX_WIDTH'(i);
            end
        end
    end
`else
    assign first_idx = '0;
    assign next_idx  = stream.out_index + 1'b1;
`endif

    // Node 0 comes straight from the input bus so it is valid the cycle after capture.
    assign first_data = input_fc[DATA_WIDTH*first_idx +: DATA_WIDTH];
    assign next_data  = frame_q[DATA_WIDTH*next_idx +: DATA_WIDTH];

    // Frame buffer contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q <= input_fc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            done_prev_q      <= 1'b0;
            stream.out_data  <= '0;
            stream.out_index <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            drop_err         <= 1'b0;
        end else begin
            done_prev_q <= done_flag;
            frame_done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q          <= StStream;
                        stream.out_data  <= first_data;
                        stream.out_index <= first_idx;
                        stream.out_last  <= (first_idx == LastIdx);
                        stream.out_valid <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                StStream: begin
                    if (start_edge) begin
                        drop_err <= 1'b1;
                    end
                    if (beat_accept) begin
                        if (stream.out_last) begin
                            state_q          <= StIdle;
                            stream.out_data  <= '0;
                            stream.out_index <= '0;
                            stream.out_last  <= 1'b0;
                            stream.out_valid <= 1'b0;
                            busy             <= 1'b0;
                            frame_done       <= 1'b1;
                        end else begin
                            stream.out_data  <= next_data;
                            stream.out_index <= next_idx;
                            stream.out_last  <= (next_idx == LastIdx);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
